uart_dbg_bridge: RTL and testbench
==================================

Name: uart_dbg_bridge

Overview:
Byte-stream debug master sitting directly downstream of the SoC UART RX deserializer and upstream of its TX serializer. It parses host debug commands (READ 0x11, WRITE 0x12, EXEC 0x13) and issues single-word OBI master transactions into the crossbar. It answers with ACK 0x06 (plus read data) or NAK 0x15. This gives the SoC a UART boot/debug path parallel to JTAG SBA.

Parameters:
BootAddrAddr, 32'h0300_0000, OBI address of the SoC-control boot-address register, written by EXEC.
FetchEnAddr, 32'h0300_0004, OBI address of the SoC-control fetch-enable register, written by EXEC.
TimeoutCycles, 32'd100000, inter-byte RX timeout in clk_i cycles (only with UART_DBG_TIMEOUT_EN).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
rx_valid_i  in  1  RX byte valid
rx_data_i  in  8  RX byte
rx_ready_o  out  1  bridge accepts RX byte
tx_valid_o  out  1  TX byte valid
tx_data_o  out  8  TX byte
tx_ready_i  in  1  serializer accepts TX byte
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  32  OBI address, word aligned
obi_we_o  out  1  OBI write enable
obi_be_o  out  4  OBI byte enable, always 4'hF
obi_wdata_o  out  32  OBI write data
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  32  OBI read data
obi_err_i  in  1  OBI error, sampled with rvalid
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters and holding registers 0.
- RX handshake: byte consumed on rx_valid_i && rx_ready_o. rx_ready_o is 1 only in IDLE, ADDR and DATA.
- TX handshake: byte sent on tx_valid_o && tx_ready_i. tx_data_o is stable while tx_valid_o=1 and not accepted.
- Multi-byte fields are little-endian (LSB first), 4 bytes each. A 2-bit byte counter wraps 3->0 at field end.
- FSM states: IDLE, ADDR, DATA, OBI_REQ, OBI_WAIT, RESP, RDATA.
- IDLE: byte 0x11/0x12/0x13 latches the command and goes to ADDR. Any other byte is consumed and dropped; no response.
- ADDR: after 4 bytes, READ/EXEC go to OBI_REQ and WRITE goes to DATA. addr[1:0] is forced to 0 on the bus.
- DATA: after 4 bytes, go to OBI_REQ.
- OBI_REQ: obi_req_o=1 with addr/we/wdata stable until obi_gnt_i. The grant may arrive in the same cycle req rises. On grant, drop req next cycle and go to OBI_WAIT. Only one transaction is outstanding.
- OBI_WAIT: on obi_rvalid_i, capture rdata and OR err into a sticky error flag.
  - EXEC step 1 (we=1, BootAddrAddr <- received addr) returns to OBI_REQ for step 2 (FetchEnAddr <- 32'h1).
  - Otherwise go to RESP.
  - rvalid arriving in the same cycle as gnt is legal and must be handled.
- RESP: send 0x06, or 0x15 if the error flag is set.
  - READ with no error goes to RDATA.
  - Otherwise return to IDLE and clear the error flag.
  - EXEC step 2 is still issued even if step 1 errored; a single NAK is reported.
- RDATA: send 4 rdata bytes LSB first, then IDLE.
- Latency: OBI request asserted the cycle after the last field byte is accepted. ACK valid the cycle after rvalid.
- Bytes arriving in OBI_*/RESP/RDATA are back-pressured (not dropped).
- Async reset mid-transaction returns to IDLE immediately; an in-flight OBI response after reset is ignored.

Optional Feature:
- UART_DBG_TIMEOUT_EN defined: a counter of width $clog2(TimeoutCycles+1) runs in ADDR/DATA and clears on each accepted byte. When it reaches TimeoutCycles, return to IDLE silently (no TX) and discard the partial command.
- Not defined: no counter; ADDR/DATA wait indefinitely.

Decomposition:
- uart_dbg_pkg: command/response byte constants (CmdRead 8'h11, CmdWrite 8'h12, CmdExec 8'h13, Ack 8'h06, Nak 8'h15), FSM state enum, command enum.
- Single module. No sub-module is warranted; the shift-in/shift-out field registers stay inline.

Test Plan:
- WRITE: bytes 12 00 00 00 10 78 56 34 12 -> one OBI write, addr 0x1000_0000, wdata 0x1234_5678, be F; TX 06.
- READ: 11 00 00 00 10, slave returns 0x1234_5678 -> TX 06 78 56 34 12. Run with gnt delayed 3 cycles and with gnt+rvalid same cycle.
- EXEC: 13 80 00 00 10 -> writes 0x1000_0080 to BootAddrAddr, then 0x1 to FetchEnAddr in order; single TX 06.
- Error and back-pressure: READ with err_i=1 -> TX 15 only, no data bytes. Hold tx_ready_i=0 for 50 cycles -> tx_data_o stable throughout.
- Robustness: unknown byte 0x42 then a valid WRITE -> 0x42 ignored, WRITE completes normally. rst_ni pulsed in OBI_WAIT -> outputs 0, next command works.
- Timeout (macro on, TimeoutCycles=100): 11 00 00 then idle 100 cycles -> busy_o falls with no TX. A following full READ succeeds.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: shared definitions for the UART debug bridge.
//   Command/response byte codes, FSM state encoding, command encoding and
//   small byte-classification helpers. No ports (package).
package uart_dbg_pkg;
  localparam logic [7:0] CmdRead  = 8'h11;
  localparam logic [7:0] CmdWrite = 8'h12;
  localparam logic [7:0] CmdExec  = 8'h13;
  localparam logic [7:0] Ack      = 8'h06;
  localparam logic [7:0] Nak      = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OBI_REQ,
    S_OBI_WAIT,
    S_RESP,
    S_RDATA
  } state_e;

  typedef enum logic [1:0] {
    CMD_READ,
    CMD_WRITE,
    CMD_EXEC
  } cmd_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return b inside {CmdRead, CmdWrite, CmdExec};
  endfunction

  function automatic cmd_e decode_cmd(input logic [7:0] b);
    return b == CmdRead ? CMD_READ : b == CmdWrite ? CMD_WRITE : CMD_EXEC;
  endfunction
endpackage

// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART byte-stream debug master issuing single-word OBI transactions.
//   Optional build macro: UART_DBG_TIMEOUT_EN (inter-byte RX timeout in ADDR/DATA).
//   Ports:
//     clk_i, rst_ni                          clock, asynchronous active-low reset
//     rx_valid_i, rx_data_i, rx_ready_o      byte stream from the UART RX deserializer
//     tx_valid_o, tx_data_o, tx_ready_i      byte stream to the UART TX serializer
//     obi_req_o, obi_gnt_i, obi_addr_o,
//     obi_we_o, obi_be_o, obi_wdata_o        OBI master request channel
//     obi_rvalid_i, obi_rdata_i, obi_err_i   OBI response channel
//     busy_o                                 high whenever the FSM is not idle
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter logic [31:0] BootAddrAddr  = 32'h0300_0000,
  parameter logic [31:0] FetchEnAddr   = 32'h0300_0004,
  parameter int unsigned TimeoutCycles = 32'd100000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o
);
  state_e      state;
  cmd_e        cmd;
  logic [1:0]  cnt;
  logic [23:0] field_sr;
  logic [31:0] rdata;
  logic        err;
  logic        step;
  logic        rx_accept;
  logic        rsp_fire;
  logic        err_next;
  logic        tmo_hit;
  logic [31:0] field;

  assign rx_accept = rx_valid_i && rx_ready_o;
  // The fourth byte completes the field together with the three already shifted in.
  assign field     = {rx_data_i, field_sr};
  // A response is legal in the grant cycle itself, not only in OBI_WAIT.
  assign rsp_fire  = obi_rvalid_i && (state == S_OBI_WAIT || (state == S_OBI_REQ && obi_gnt_i));
  assign err_next  = err | obi_err_i;
  assign busy_o    = state != S_IDLE;

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = (state inside {S_ADDR, S_DATA}) && !rx_accept && tmo == TW'(TimeoutCycles);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) tmo <= '0;
    else tmo <= (state inside {S_ADDR, S_DATA}) && !rx_accept && !tmo_hit ? tmo + TW'(1) : '0;
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      cmd         <= CMD_READ;
      cnt         <= '0;
      field_sr    <= '0;
      rdata       <= '0;
      err         <= 1'b0;
      step        <= 1'b0;
      rx_ready_o  <= 1'b0;
      tx_valid_o  <= 1'b0;
      tx_data_o   <= '0;
      obi_req_o   <= 1'b0;
      obi_addr_o  <= '0;
      obi_we_o    <= 1'b0;
      obi_be_o    <= '0;
      obi_wdata_o <= '0;
    end else begin
      obi_be_o <= 4'hF;
      case (state)
        S_IDLE: begin
          rx_ready_o <= 1'b1;
          if (rx_accept && is_cmd(rx_data_i)) begin
            cmd   <= decode_cmd(rx_data_i);
            cnt   <= '0;
            step  <= 1'b0;
            state <= S_ADDR;
          end
        end
        S_ADDR: if (rx_accept) begin
          field_sr <= field[31:8];
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // EXEC first writes the received address into the boot-address register.
            obi_addr_o  <= cmd == CMD_EXEC ? BootAddrAddr : {field[31:2], 2'b00};
            obi_wdata_o <= cmd == CMD_EXEC ? field : 32'h0;
            obi_we_o    <= cmd != CMD_READ;
            if (cmd == CMD_WRITE) state <= S_DATA;
            else begin
              state      <= S_OBI_REQ;
              obi_req_o  <= 1'b1;
              rx_ready_o <= 1'b0;
            end
          end
        end
        S_DATA: if (rx_accept) begin
          field_sr <= field[31:8];
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            obi_wdata_o <= field;
            obi_req_o   <= 1'b1;
            rx_ready_o  <= 1'b0;
            state       <= S_OBI_REQ;
          end
        end
        S_OBI_REQ: if (obi_gnt_i) begin
          obi_req_o <= 1'b0;
          if (!obi_rvalid_i) state <= S_OBI_WAIT;
        end
        S_OBI_WAIT: ;
        S_RESP: if (tx_ready_i) begin
          if (cmd == CMD_READ && !err) begin
            state     <= S_RDATA;
            tx_data_o <= rdata[7:0];
            rdata     <= rdata >> 8;
            cnt       <= '0;
          end else begin
            tx_valid_o <= 1'b0;
            err        <= 1'b0;
            rx_ready_o <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_RDATA: if (tx_ready_i) begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            tx_valid_o <= 1'b0;
            rx_ready_o <= 1'b1;
            state      <= S_IDLE;
          end else begin
            tx_data_o <= rdata[7:0];
            rdata     <= rdata >> 8;
          end
        end
        default: state <= S_IDLE;
      endcase
      // Response handling overrides the per-state defaults above.
      if (rsp_fire) begin
        rdata <= obi_rdata_i;
        err   <= err_next;
        if (cmd == CMD_EXEC && !step) begin
          step        <= 1'b1;
          state       <= S_OBI_REQ;
          obi_req_o   <= 1'b1;
          obi_addr_o  <= FetchEnAddr;
          obi_wdata_o <= 32'h1;
        end else begin
          step       <= 1'b0;
          state      <= S_RESP;
          tx_valid_o <= 1'b1;
          tx_data_o  <= err_next ? Nak : Ack;
        end
      end
      // A stalled partial command is discarded without any reply.
      if (tmo_hit) begin
        state    <= S_IDLE;
        cnt      <= '0;
        field_sr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_dbg_bridge.sv
// tb_uart_dbg_bridge: randomized self-checking bench with a command-level reference model.
module tb_uart_dbg_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;
  logic        busy;

  localparam logic [31:0] BOOT = 32'h0300_0000;
  localparam logic [31:0] FEN  = 32'h0300_0004;

  uart_dbg_bridge #(.TimeoutCycles(100)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
    .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
    .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          req_cyc;
    int          rv_cyc;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] rsp_rd[$];
  logic        rsp_err[$];
  int          s_idx, m_idx;
  int          total = 0, bad = 0, cyc = 0;
  int          gnt_delay = 0, rsp_delay = 1, tx_mode = 0, gap_max = 0;
  int          txv_cyc = -1, last_acc = 0;
  logic        txv_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // OBI slave: grant after gnt_delay cycles of request, respond rsp_delay cycles after grant.
  initial begin
    int gnt_cnt, rsp_left, cur_req_cyc;
    bit have_rsp;
    logic [31:0] pend_rd;
    logic pend_err;
    gnt_cnt = 0; rsp_left = 0; have_rsp = 0; cur_req_cyc = 0; pend_rd = 0; pend_err = 0;
    obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0; obi_err = 0;
    forever begin
      @(negedge clk);
      obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0; obi_err = 0;
      if (have_rsp) begin
        if (rsp_left == 0) begin
          obi_rvalid = 1; obi_rdata = pend_rd; obi_err = pend_err; have_rsp = 0;
          if (obs_q.size() > 0) obs_q[obs_q.size()-1].rv_cyc = cyc;
        end else rsp_left--;
      end
      if (obi_req && rst_n) begin
        if (gnt_cnt == 0) cur_req_cyc = cyc;
        if (gnt_cnt >= gnt_delay) begin
          obi_gnt = 1; gnt_cnt = 0;
          pend_rd  = s_idx < rsp_rd.size() ? rsp_rd[s_idx] : 32'h0;
          pend_err = s_idx < rsp_err.size() ? rsp_err[s_idx] : 1'b0;
          s_idx++;
          obs_q.push_back('{obi_addr, obi_we, obi_wdata, obi_be, cur_req_cyc, -1});
          if (rsp_delay == 0) begin
            obi_rvalid = 1; obi_rdata = pend_rd; obi_err = pend_err;
            obs_q[obs_q.size()-1].rv_cyc = cyc;
          end else begin
            have_rsp = 1; rsp_left = rsp_delay - 1;
          end
        end else gnt_cnt++;
      end
    end
  end

  // TX sink: records accepted bytes and the cycle tx_valid first rises.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      tx_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      if (tx_valid && !txv_prev && txv_cyc < 0) txv_cyc = cyc;
      txv_prev = tx_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rd_at(input int i);
    return i < rsp_rd.size() ? rsp_rd[i] : 32'h0;
  endfunction

  function automatic logic err_at(input int i);
    return i < rsp_err.size() ? rsp_err[i] : 1'b0;
  endfunction

  // Reference model: the OBI transactions and reply bytes one host command should produce.
  task automatic model_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    if (c == 8'h11) begin
      exp_q.push_back('{a & ~32'h3, 1'b0, 32'h0, 4'hF, 0, 0});
      r = rd_at(m_idx); e = err_at(m_idx); m_idx++;
      exp_tx.push_back(e ? 8'h15 : 8'h06);
      if (!e) for (int i = 0; i < 4; i++) exp_tx.push_back(8'((r >> (8 * i)) & 32'hFF));
    end else if (c == 8'h12) begin
      exp_q.push_back('{a & ~32'h3, 1'b1, d, 4'hF, 0, 0});
      e = err_at(m_idx); m_idx++;
      exp_tx.push_back(e ? 8'h15 : 8'h06);
    end else if (c == 8'h13) begin
      exp_q.push_back('{BOOT, 1'b1, a, 4'hF, 0, 0});
      exp_q.push_back('{FEN, 1'b1, 32'h1, 4'hF, 0, 0});
      e = err_at(m_idx) | err_at(m_idx + 1); m_idx += 2;
      exp_tx.push_back(e ? 8'h15 : 8'h06);
    end
  endtask

  task automatic clear();
    obs_q.delete(); exp_q.delete(); tx_q.delete(); exp_tx.delete();
    rsp_rd.delete(); rsp_err.delete();
    s_idx = 0; m_idx = 0; txv_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    while (!rx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL rx_accept: byte %h not accepted, rx_ready=%b required 1 within 2000 cycles", b, rx_ready);
    end
    @(negedge clk);
    last_acc = cyc;
    rx_valid = 1'b0; rx_data = 8'h0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(c);
    if (c inside {8'h11, 8'h12, 8'h13})
      for (int i = 0; i < 4; i++) send_byte(8'((a >> (8 * i)) & 32'hFF));
    if (c == 8'h12)
      for (int i = 0; i < 4; i++) send_byte(8'((d >> (8 * i)) & 32'hFF));
    model_cmd(c, a, d);
  endtask

  task automatic check_all(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 5000) begin
      bad++;
      $display("FAIL %s idle: busy=%b required 0 within 5000 cycles", name, busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (obs_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s obi_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].we !== exp_q[i].we || obs_q[i].be !== exp_q[i].be
          || (exp_q[i].we && obs_q[i].wdata !== exp_q[i].wdata)) begin
        bad++;
        $display("FAIL %s obi[%0d]: got addr=%h we=%b be=%h wdata=%h required addr=%h we=%b be=%h wdata=%h",
                 name, i, obs_q[i].addr, obs_q[i].we, obs_q[i].be, obs_q[i].wdata,
                 exp_q[i].addr, exp_q[i].we, exp_q[i].be, exp_q[i].wdata);
      end
    end
    total++;
    if (tx_q.size() !== exp_tx.size()) begin
      bad++;
      $display("FAIL %s tx_count: got %0d required %0d", name, tx_q.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
      total++;
      if (tx_q[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL %s tx[%0d]: got %h required %h", name, i, tx_q[i], exp_tx[i]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({rx_ready, tx_valid, tx_data, obi_req, obi_addr, obi_we, obi_be, obi_wdata, busy} !== '0) begin
      bad++;
      $display("FAIL %s outputs: got rdy=%b txv=%b txd=%h req=%b addr=%h we=%b be=%h wd=%h busy=%b required all 0",
               name, rx_ready, tx_valid, tx_data, obi_req, obi_addr, obi_we, obi_be, obi_wdata, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got rx_ready=%b busy=%b required 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write();
    clear(); gnt_delay = 1; rsp_delay = 1; tx_mode = 0; gap_max = 1;
    send_cmd(8'h12, 32'h1000_0000, 32'h1234_5678);
    check_all("write");
  endtask

  task automatic test_read();
    clear(); gnt_delay = 3; rsp_delay = 2; tx_mode = 0; gap_max = 0;
    rsp_rd.push_back(32'h1234_5678); rsp_err.push_back(1'b0);
    send_cmd(8'h11, 32'h1000_0000, 32'h0);
    check_all("read_gnt3");
    total++;
    if (obs_q.size() > 0 && obs_q[0].req_cyc !== last_acc) begin
      bad++;
      $display("FAIL read_req_latency: req seen at cycle %0d required %0d", obs_q[0].req_cyc, last_acc);
    end
    total++;
    if (obs_q.size() > 0 && txv_cyc !== obs_q[0].rv_cyc + 1) begin
      bad++;
      $display("FAIL read_ack_latency: tx_valid at cycle %0d required %0d", txv_cyc, obs_q[0].rv_cyc + 1);
    end
    clear(); gnt_delay = 0; rsp_delay = 0;
    rsp_rd.push_back($urandom); rsp_err.push_back(1'b0);
    send_cmd(8'h11, $urandom, 32'h0);
    check_all("read_same_cycle");
    total++;
    if (obs_q.size() > 0 && txv_cyc !== obs_q[0].rv_cyc + 1) begin
      bad++;
      $display("FAIL read_same_cycle_ack_latency: tx_valid at cycle %0d required %0d", txv_cyc, obs_q[0].rv_cyc + 1);
    end
  endtask

  task automatic test_exec();
    clear(); gnt_delay = 2; rsp_delay = 1; tx_mode = 0;
    send_cmd(8'h13, 32'h1000_0080, 32'h0);
    check_all("exec");
    clear(); gnt_delay = 0; rsp_delay = 0;
    send_cmd(8'h13, $urandom, 32'h0);
    check_all("exec_same_cycle");
  endtask

  task automatic test_error();
    clear(); gnt_delay = 1; rsp_delay = 2; tx_mode = 0;
    rsp_rd.push_back($urandom); rsp_err.push_back(1'b1);
    send_cmd(8'h11, $urandom, 32'h0);
    check_all("read_err");
    clear();
    rsp_err.push_back(1'b1); rsp_err.push_back(1'b0);
    send_cmd(8'h13, $urandom, 32'h0);
    check_all("exec_err_step1");
    clear();
    rsp_err.push_back(1'b1);
    send_cmd(8'h12, $urandom, $urandom);
    check_all("write_err");
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    logic stable;
    logic rx_blocked;
    int n;
    clear(); gnt_delay = 0; rsp_delay = 1; tx_mode = 2;
    rsp_rd.push_back($urandom); rsp_err.push_back(1'b0);
    send_cmd(8'h11, $urandom, 32'h0);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!tx_valid) begin
      bad++;
      $display("FAIL bp_tx_valid: got %b required 1 within 200 cycles", tx_valid);
    end
    d0 = tx_data; stable = 1'b1; rx_blocked = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_data !== d0 || tx_valid !== 1'b1) stable = 1'b0;
      if (rx_ready !== 1'b0) rx_blocked = 1'b0;
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL bp_tx_stable: tx_data=%h tx_valid=%b required %h held with valid 1", tx_data, tx_valid, d0);
    end
    total++;
    if (!rx_blocked) begin
      bad++;
      $display("FAIL bp_rx_ready: got rx_ready=%b required 0 while replying", rx_ready);
    end
    tx_mode = 0;
    check_all("backpressure");
  endtask

  task automatic test_unknown();
    clear(); gnt_delay = 1; rsp_delay = 1; tx_mode = 0;
    send_cmd(8'h42, 32'h0, 32'h0);
    send_cmd(8'h12, $urandom, $urandom);
    check_all("unknown_then_write");
  endtask

  task automatic test_reset_mid();
    int n;
    clear(); gnt_delay = 0; rsp_delay = 8; tx_mode = 0;
    send_cmd(8'h11, $urandom, 32'h0);
    n = 0;
    while (obs_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (tx_q.size() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_quiet: got tx bytes=%0d busy=%b required 0 0", tx_q.size(), busy);
    end
    clear(); rsp_delay = 1;
    send_cmd(8'h12, $urandom, $urandom);
    check_all("after_reset_write");
  endtask

`ifdef UART_DBG_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    clear(); gnt_delay = 0; rsp_delay = 1; tx_mode = 0; gap_max = 0;
    send_byte(8'h11); send_byte(8'h00); send_byte(8'h00);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy || cyc - last_acc < 100 || cyc - last_acc > 102) begin
      bad++;
      $display("FAIL timeout: busy=%b fell after %0d cycles required 0 after 100..102", busy, cyc - last_acc);
    end
    total++;
    if (tx_q.size() !== 0) begin
      bad++;
      $display("FAIL timeout_tx: got %0d bytes required 0", tx_q.size());
    end
    clear();
    rsp_rd.push_back($urandom);
    send_cmd(8'h11, $urandom, 32'h0);
    check_all("read_after_timeout");
  endtask
`endif

  task automatic test_random();
    int kind;
    logic [7:0] c;
    logic [31:0] a, d;
    for (int k = 0; k < 25; k++) begin
      clear();
      gnt_delay = $urandom_range(0, 4); rsp_delay = $urandom_range(0, 4);
      tx_mode = 1; gap_max = $urandom_range(0, 3);
      for (int j = 0; j < 2; j++) begin
        rsp_rd.push_back($urandom);
        rsp_err.push_back($urandom_range(0, 4) == 0);
      end
      kind = $urandom_range(0, 3);
      a = $urandom; d = $urandom;
      c = 8'($urandom);
      while (c inside {8'h11, 8'h12, 8'h13}) c = 8'($urandom);
      if (kind != 0) c = 8'h10 + 8'(kind);
      send_cmd(c, a, d);
      check_all("random");
    end
  endtask

  task automatic test_back_to_back();
    clear(); gnt_delay = 1; rsp_delay = 1; tx_mode = 0; gap_max = 0;
    for (int j = 0; j < 4; j++) begin
      rsp_rd.push_back($urandom);
      rsp_err.push_back(1'b0);
    end
    send_cmd(8'h11, $urandom, 32'h0);
    send_cmd(8'h12, $urandom, $urandom);
    send_cmd(8'h13, $urandom, 32'h0);
    check_all("back_to_back");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_exec();
    test_error();
    test_backpressure();
    test_unknown();
    test_reset_mid();
`ifdef UART_DBG_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
